// File: rtl/load_store_unit_if.sv
// Request/response handshake between the EX/MEM stage (master) and the
// load/store unit (slave).
interface load_store_unit_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: drives a synchronous byte-enabled word RAM, extends loads,
// and optionally splits word-boundary-crossing accesses into two beats.
module load_store_unit #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int MISALIGNED_EN = 1,
  localparam int NB           = DATA_W / 8,
  localparam int OFF_W        = $clog2(NB),
  localparam int WORD_AW      = ADDR_W - OFF_W
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output logic               mem_en,
  output logic [NB-1:0]      mem_be,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  typedef struct packed {
    logic       legal;
    logic       sgn;
    logic [3:0] size;
  } dec_t;

  function automatic dec_t decode(input logic we, input logic [2:0] f3);
    dec_t d;
    d.legal = 1'b0;
    d.sgn   = 1'b1;
    d.size  = 4'd1;
    case (f3)
      3'b000: d.legal = 1'b1;
      3'b001: begin d.legal = 1'b1; d.size = 4'd2; end
      3'b010: begin d.legal = 1'b1; d.size = 4'd4; end
      3'b011: begin d.legal = (DATA_W == 64); d.size = 4'd8; end
      3'b100: begin d.legal = !we; d.sgn = 1'b0; end
      3'b101: begin d.legal = !we; d.sgn = 1'b0; d.size = 4'd2; end
      3'b110: begin d.legal = !we && (DATA_W == 64); d.sgn = 1'b0; d.size = 4'd4; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_t              state_reg;
  logic                ready_reg, valid_reg, err_reg;
  logic                we_reg, sgn_reg, split_reg;
  logic [OFF_W-1:0]    off_reg;
  logic [3:0]          size_reg;
  logic [NB-1:0]       be_hi_reg;
  logic [DATA_W-1:0]   wd_hi_reg;
  logic [DATA_W-1:0]   hold_reg;

  dec_t                in_dec;
  logic [OFF_W-1:0]    in_off;
  logic                in_split;
  logic [2*NB-1:0]     in_be_wide;
  logic [2*DATA_W-1:0] in_wd_wide;

  assign in_dec     = decode(bus.req_we, bus.req_funct3);
  assign in_off     = bus.req_addr[OFF_W-1:0];
  assign in_split   = (int'(in_off) + int'(in_dec.size)) > NB;
  // Low half of each shifted vector feeds beat 0, high half is kept for beat 1.
  assign in_be_wide = (((2*NB)'(1) << in_dec.size) - (2*NB)'(1)) << in_off;
  assign in_wd_wide = {{DATA_W{1'b0}}, bus.req_wdata} << {in_off, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      mem_en    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_reg    <= 1'b0;
      sgn_reg   <= 1'b0;
      split_reg <= 1'b0;
      off_reg   <= '0;
      size_reg  <= '0;
      be_hi_reg <= '0;
      wd_hi_reg <= '0;
      hold_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            we_reg    <= bus.req_we;
            sgn_reg   <= in_dec.sgn;
            split_reg <= in_split;
            off_reg   <= in_off;
            size_reg  <= in_dec.size;
            be_hi_reg <= in_be_wide[2*NB-1:NB];
            wd_hi_reg <= in_wd_wide[2*DATA_W-1:DATA_W];
            ready_reg <= 1'b0;
            if (!in_dec.legal || (in_split && MISALIGNED_EN == 0)) begin
              err_reg   <= 1'b1;
              valid_reg <= 1'b1;
              state_reg <= DONE;
            end else begin
              mem_en    <= 1'b1;
              mem_addr  <= bus.req_addr[ADDR_W-1:OFF_W];
              mem_be    <= bus.req_we ? in_be_wide[NB-1:0] : '0;
              mem_wdata <= bus.req_we ? in_wd_wide[DATA_W-1:0] : '0;
              state_reg <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (split_reg) begin
            mem_addr  <= mem_addr + WORD_AW'(1);
            mem_be    <= we_reg ? be_hi_reg : '0;
            mem_wdata <= we_reg ? wd_hi_reg : '0;
            state_reg <= BEAT1;
          end else begin
            mem_en    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end
        end
        BEAT1: begin
          hold_reg  <= mem_rdata;
          mem_en    <= 1'b0;
          mem_be    <= '0;
          mem_wdata <= '0;
          valid_reg <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          valid_reg <= 1'b0;
          err_reg   <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Read data only exists in DONE, so alignment and extension stay combinational.
  logic [2*DATA_W-1:0] rd_wide;
  logic [DATA_W-1:0]   rd_al, rd_ext;
  logic                sign_bit;

  assign rd_wide = split_reg ? {mem_rdata, hold_reg} : {{DATA_W{1'b0}}, mem_rdata};
  assign rd_al   = DATA_W'(rd_wide >> {off_reg, 3'b000});

  always_comb begin
    sign_bit = sgn_reg & rd_al[DATA_W-1];
    case (size_reg)
      4'd1:    sign_bit = sgn_reg & rd_al[7];
      4'd2:    sign_bit = sgn_reg & rd_al[15];
      4'd4:    sign_bit = sgn_reg & rd_al[31];
      default: sign_bit = sgn_reg & rd_al[DATA_W-1];
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_ext
      localparam logic [3:0] LANE = 4'(gi / 8);
      assign rd_ext[gi] = (LANE < size_reg) ? rd_al[gi] : sign_bit;
    end
  endgenerate

  assign bus.req_ready  = ready_reg;
  assign bus.resp_valid = valid_reg;
  assign bus.resp_err   = err_reg;
  assign bus.resp_rdata = (state_reg == DONE && !we_reg && !err_reg) ? rd_ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written reset abort,
// and random traffic checked against a byte-array memory model.
module tb_load_store_unit;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_a ();
  load_store_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_b ();

  logic        a_mem_en, b_mem_en;
  logic [3:0]  a_mem_be, b_mem_be;
  logic [6:0]  a_mem_addr, b_mem_addr;
  logic [31:0] a_mem_wdata, b_mem_wdata, a_mem_rdata, b_mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MISALIGNED_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a),
    .mem_en(a_mem_en), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MISALIGNED_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b),
    .mem_en(b_mem_en), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Shared request drive, steered to one unit by sel.
  logic        sel = 1'b0;
  logic        t_valid = 1'b0, t_we = 1'b0;
  logic [2:0]  t_f3 = 3'd0;
  logic [8:0]  t_addr = 9'd0;
  logic [31:0] t_wd = 32'd0;

  assign if_a.req_valid  = t_valid & ~sel;
  assign if_b.req_valid  = t_valid & sel;
  assign if_a.req_we     = t_we;
  assign if_b.req_we     = t_we;
  assign if_a.req_funct3 = t_f3;
  assign if_b.req_funct3 = t_f3;
  assign if_a.req_addr   = t_addr;
  assign if_b.req_addr   = t_addr;
  assign if_a.req_wdata  = t_wd;
  assign if_b.req_wdata  = t_wd;

  logic        m_en, rv, re;
  logic [3:0]  m_be;
  logic [6:0]  m_addr;
  logic [31:0] m_wd, rd;
  assign m_en   = sel ? b_mem_en : a_mem_en;
  assign m_be   = sel ? b_mem_be : a_mem_be;
  assign m_addr = sel ? b_mem_addr : a_mem_addr;
  assign m_wd   = sel ? b_mem_wdata : a_mem_wdata;
  assign rv     = sel ? if_b.resp_valid : if_a.resp_valid;
  assign rd     = sel ? if_b.resp_rdata : if_a.resp_rdata;
  assign re     = sel ? if_b.resp_err : if_a.resp_err;

  // RAM behind unit A: synchronous, byte-enabled, read-before-write.
  logic [31:0] ram_a [128];
  logic        fill = 1'b0;
  logic [6:0]  fill_idx = 7'd0;
  logic [31:0] fill_word = 32'd0;
  always @(posedge clk) begin
    if (fill) ram_a[fill_idx] <= fill_word;
    else if (a_mem_en) begin
      for (int b = 0; b < 4; b++)
        if (a_mem_be[b]) ram_a[a_mem_addr][8*b +: 8] <= a_mem_wdata[8*b +: 8];
      a_mem_rdata <= ram_a[a_mem_addr];
    end
  end
  assign b_mem_rdata = 32'hCAFEF00D;

  // Reference model: flat byte memory, little-endian, address wraps at 512.
  logic [7:0] ref_mem [512];
  int n_checks = 0;
  int n_err = 0;

  function automatic int f_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0: return 1;
      2'd1: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit f_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic [31:0] ref_load(input logic [8:0] addr, input logic [2:0] f3);
    logic [31:0] v;
    int n;
    v = 32'd0;
    n = f_size(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) % 512];
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [8:0] addr, input logic [2:0] f3, input logic [31:0] wd, input int nbytes);
    for (int i = 0; i < nbytes && i < f_size(f3); i++) ref_mem[(int'(addr) + i) % 512] = wd[8*i +: 8];
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_txn(input bit s, input bit we, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                         output logic err, output int nb, output logic [13:0] baddr,
                         output logic [7:0] bbe, output logic [63:0] bwd);
    lat = 0; nb = 0; rdata = 32'd0; err = 1'b0;
    baddr = 14'd0; bbe = 8'd0; bwd = 64'd0;
    @(negedge clk);
    sel = s;
    chk("ready_before_req", {63'd0, (s ? if_b.req_ready : if_a.req_ready)}, 64'd1);
    t_valid = 1'b1; t_we = we; t_f3 = f3; t_addr = addr; t_wd = wd;
    @(negedge clk);
    t_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (m_en) begin
        if (nb == 0) begin baddr[6:0] = m_addr; bbe[3:0] = m_be; bwd[31:0] = m_wd; end
        else if (nb == 1) begin baddr[13:7] = m_addr; bbe[7:4] = m_be; bwd[63:32] = m_wd; end
        nb++;
      end
      if (rv) begin
        lat = k; rdata = rd; err = re;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("pulse_end_valid_ready", {62'd0, rv, (s ? if_b.req_ready : if_a.req_ready)}, 64'd1);
    if (!s && we && f_legal(we, f3)) ref_store(addr, f3, wd, 4);
  endtask

  typedef struct {
    bit          s;
    bit          we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
    int          lat;
    int          nb;
    logic [13:0] baddr;
    logic [7:0]  bbe;
    logic [63:0] bwd;
  } vec_t;

  vec_t vt [17];

  initial begin
    int lat, nb;
    logic [31:0] got_rd, exp_rd;
    logic got_err;
    logic [13:0] baddr;
    logic [7:0] bbe;
    logic [63:0] bwd;

    vt[0]  = '{1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, {7'd0, 7'd4}, 8'h0F, 64'h00000000_DEADBEEF};
    vt[1]  = '{1'b0, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, {7'd0, 7'd4}, 8'h00, 64'h0};
    vt[2]  = '{1'b0, 1'b1, 3'b000, 9'h013, 32'h00000080, 32'h0, 1'b0, 2, 1, {7'd0, 7'd4}, 8'h08, 64'h00000000_80000000};
    vt[3]  = '{1'b0, 1'b0, 3'b000, 9'h013, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, {7'd0, 7'd4}, 8'h00, 64'h0};
    vt[4]  = '{1'b0, 1'b0, 3'b100, 9'h013, 32'h0, 32'h00000080, 1'b0, 2, 1, {7'd0, 7'd4}, 8'h00, 64'h0};
    vt[5]  = '{1'b0, 1'b1, 3'b010, 9'h00E, 32'h11223344, 32'h0, 1'b0, 3, 2, {7'd4, 7'd3}, 8'h3C, 64'h00001122_33440000};
    vt[6]  = '{1'b0, 1'b0, 3'b010, 9'h00E, 32'h0, 32'h11223344, 1'b0, 3, 2, {7'd4, 7'd3}, 8'h00, 64'h0};
    vt[7]  = '{1'b0, 1'b1, 3'b001, 9'h1FF, 32'h0000A5B6, 32'h0, 1'b0, 3, 2, {7'd0, 7'd127}, 8'h18, 64'h000000A5_B6000000};
    vt[8]  = '{1'b0, 1'b0, 3'b001, 9'h1FF, 32'h0, 32'hFFFFA5B6, 1'b0, 3, 2, {7'd0, 7'd127}, 8'h00, 64'h0};
    vt[9]  = '{1'b0, 1'b0, 3'b101, 9'h1FF, 32'h0, 32'h0000A5B6, 1'b0, 3, 2, {7'd0, 7'd127}, 8'h00, 64'h0};
    vt[10] = '{1'b0, 1'b0, 3'b111, 9'h010, 32'h0, 32'h0, 1'b1, 1, 0, 14'd0, 8'h00, 64'h0};
    vt[11] = '{1'b0, 1'b1, 3'b100, 9'h010, 32'h1234, 32'h0, 1'b1, 1, 0, 14'd0, 8'h00, 64'h0};
    vt[12] = '{1'b0, 1'b0, 3'b011, 9'h008, 32'h0, 32'h0, 1'b1, 1, 0, 14'd0, 8'h00, 64'h0};
    vt[13] = '{1'b1, 1'b0, 3'b010, 9'h002, 32'h0, 32'h0, 1'b1, 1, 0, 14'd0, 8'h00, 64'h0};
    vt[14] = '{1'b1, 1'b0, 3'b111, 9'h000, 32'h0, 32'h0, 1'b1, 1, 0, 14'd0, 8'h00, 64'h0};
    vt[15] = '{1'b1, 1'b0, 3'b010, 9'h004, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, {7'd0, 7'd1}, 8'h00, 64'h0};
    vt[16] = '{1'b1, 1'b1, 3'b001, 9'h003, 32'h5555, 32'h0, 1'b1, 1, 0, 14'd0, 8'h00, 64'h0};

    // Fill RAM and model with the same random contents while held in reset.
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      fill = 1'b1; fill_idx = 7'(i); fill_word = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = fill_word[8*b +: 8];
      if (i == 2) begin
        chk("rst_ready", {63'd0, if_a.req_ready}, 64'd1);
        chk("rst_resp", {if_a.resp_rdata, 30'd0, if_a.resp_valid, if_a.resp_err}, 64'd0);
        chk("rst_mem", {20'd0, a_mem_en, a_mem_be, a_mem_addr, a_mem_wdata}, 64'd0);
      end
    end
    @(negedge clk);
    fill = 1'b0;
    rst_n = 1'b1;

    foreach (vt[i]) begin
      run_txn(vt[i].s, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, lat, got_rd, got_err, nb, baddr, bbe, bwd);
      $display("vec %0d unit=%0d we=%0b f3=%0d addr=%h wd=%h -> rd=%h err=%0b lat=%0d beats=%0d",
               i, vt[i].s, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, got_rd, got_err, lat, nb);
      chk($sformatf("vec%0d_rdata", i), {32'd0, got_rd}, {32'd0, vt[i].rd});
      chk($sformatf("vec%0d_err", i), {63'd0, got_err}, {63'd0, vt[i].err});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("vec%0d_beats", i), 64'(nb), 64'(vt[i].nb));
      if (vt[i].nb > 0) begin
        chk($sformatf("vec%0d_mem_addr", i), {50'd0, baddr}, {50'd0, vt[i].baddr});
        chk($sformatf("vec%0d_mem_be", i), {56'd0, bbe}, {56'd0, vt[i].bbe});
        if (vt[i].we) chk($sformatf("vec%0d_mem_wdata", i), bwd, vt[i].bwd);
      end
    end

    // Reset dropped during beat 1 of a split store: beat 0 bytes stick.
    @(negedge clk);
    sel = 1'b0;
    t_valid = 1'b1; t_we = 1'b1; t_f3 = 3'b010; t_addr = 9'h01E; t_wd = 32'hA1B2C3D4;
    @(negedge clk);
    t_valid = 1'b0;
    chk("abort_beat0_addr", {56'd0, a_mem_en, a_mem_addr}, {56'd0, 1'b1, 7'd7});
    @(negedge clk);
    chk("abort_beat1_addr", {56'd0, a_mem_en, a_mem_addr}, {56'd0, 1'b1, 7'd8});
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", {63'd0, if_a.req_ready}, 64'd1);
    chk("abort_resp", {if_a.resp_rdata, 30'd0, if_a.resp_valid, if_a.resp_err}, 64'd0);
    chk("abort_mem", {20'd0, a_mem_en, a_mem_be, a_mem_addr, a_mem_wdata}, 64'd0);
    ref_store(9'h01E, 3'b010, 32'hA1B2C3D4, 2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      logic [8:0] la;
      la = (j == 0) ? 9'h000 : (j == 1) ? 9'h01C : 9'h020;
      exp_rd = ref_load(la, 3'b010);
      run_txn(1'b0, 1'b0, 3'b010, la, 32'd0, lat, got_rd, got_err, nb, baddr, bbe, bwd);
      $display("post-abort LW addr=%h -> rd=%h err=%0b lat=%0d", la, got_rd, got_err, lat);
      chk($sformatf("post_abort_rdata_%h", la), {32'd0, got_rd}, {32'd0, exp_rd});
      chk($sformatf("post_abort_latency_%h", la), 64'(lat), 64'd2);
    end

    // Random traffic on the splitting unit against the byte model.
    for (int i = 0; i < 150; i++) begin
      bit we;
      logic [2:0] f3;
      logic [8:0] addr;
      logic [31:0] wd;
      bit legal, split, exp_err;
      int exp_lat;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = (i % 8 == 0) ? 9'($urandom_range(508, 511)) : 9'($urandom_range(0, 511));
      wd   = $urandom;
      legal   = f_legal(we, f3);
      split   = (int'(addr[1:0]) + f_size(f3)) > 4;
      exp_err = !legal;
      exp_lat = !legal ? 1 : (split ? 3 : 2);
      exp_rd  = (!legal || we) ? 32'd0 : ref_load(addr, f3);
      run_txn(1'b0, we, f3, addr, wd, lat, got_rd, got_err, nb, baddr, bbe, bwd);
      $display("rnd %0d we=%0b f3=%0d addr=%h wd=%h -> rd=%h err=%0b lat=%0d",
               i, we, f3, addr, wd, got_rd, got_err, lat);
      chk("rnd_rdata", {32'd0, got_rd}, {32'd0, exp_rd});
      chk("rnd_err", {63'd0, got_err}, {63'd0, exp_err});
      chk("rnd_latency", 64'(lat), 64'(exp_lat));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Parametrised successor to the data-memory interface. Accepts CPU load/store requests over a valid/ready handshake and drives a synchronous, byte-enabled, word-wide data RAM. Sign- and zero-extends loads of every supported size. Optionally splits misaligned accesses that cross a word boundary into two RAM beats. Sits between the EX/MEM stage and the data RAM, replacing the single-cycle combinational path.

Parameters:
ADDR_W, 9, byte-address width.
DATA_W, 32, native word width; legal values 32 or 64. NB = DATA_W/8; OFF_W = log2(NB); WORD_AW = ADDR_W-OFF_W.
MISALIGNED_EN, 1, 1 = split boundary-crossing accesses into two beats; 0 = flag them as errors.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  instruction bits [14:12]
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  illegal funct3 or forbidden misalignment; qualified by resp_valid
mem_en  out  1  RAM access strobe
mem_be  out  NB  byte write enables; all 0 on reads
mem_addr  out  WORD_AW  word index
mem_wdata  out  DATA_W  lane-positioned write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en

Behaviour:
- Reset (async assert): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_en=0; mem_be=0; mem_addr=0; mem_wdata=0.
- Reset mid-operation aborts immediately. A split store may leave only beat 0 written; this is accepted behaviour.
- Size from funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; if DATA_W=64, also 011 LD and 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW; if DATA_W=64, also 011 SD.
  - Any other code is illegal.
- off = req_addr[OFF_W-1:0]. split = off+size_bytes > NB.
- FSM: IDLE, BEAT0, BEAT1, DONE. Handshake completes on req_valid & req_ready; all request fields are latched at that edge.
- IDLE: on accept, go to DONE with err=1 if funct3 is illegal, or if split and MISALIGNED_EN=0. No RAM access occurs in that case. Otherwise go to BEAT0.
- BEAT0:
  - mem_en=1; mem_addr=req_addr[ADDR_W-1:OFF_W].
  - Stores: mem_be = low NB bits of (size_mask<<off); mem_wdata = low DATA_W bits of (wdata<<8*off).
  - Next state is BEAT1 if split, else DONE.
- BEAT1:
  - mem_en=1; mem_addr = word0+1, modulo 2^WORD_AW, so the last word wraps to 0.
  - mem_be and mem_wdata are the high NB/DATA_W bits of the same shifts.
  - mem_rdata (beat 0) is captured into a hold register. Next state is DONE.
- DONE:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - Loads: resp_rdata = ({mem_rdata, hold} >> 8*off) for split accesses, or (mem_rdata >> 8*off) otherwise. The result is truncated to size and sign- or zero-extended per funct3.
  - Stores and errors: resp_rdata=0.
- Outside DONE: resp_valid=0. mem_en=0 outside BEAT0/BEAT1. mem_be=0 for loads.
- Latency from accept edge T to resp_valid:
  - error: T+1
  - aligned or non-split: T+2
  - split: T+3
- Throughput: no new accept until back in IDLE. req_valid held during busy cycles is ignored until then.

Test Plan:
- DATA_W=32: SW 0xDEADBEEF @0x010, then LW @0x010 -> beat mem_be=4'b1111, mem_addr=4; load resp_rdata=0xDEADBEEF at T+2, resp_err=0.
- SB 0x80 @0x013, then LB @0x013 and LBU @0x013 -> mem_be=4'b1000, mem_wdata=0x80000000; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- MISALIGNED_EN=1: SW 0x11223344 @0x00E -> BEAT0 addr=3, be=4'b1100, wdata=0x33440000; BEAT1 addr=4, be=4'b0011, wdata=0x00001122; LW @0x00E returns 0x11223344 at T+3.
- Wrap: SH 0xA5B6 @0x1FF -> BEAT0 addr=127, be=4'b1000; BEAT1 addr=0, be=4'b0001. LH @0x1FF returns 0xFFFFA5B6.
- MISALIGNED_EN=0: LW @0x002 -> no mem_en; resp_valid at T+1 with resp_err=1, rdata=0. funct3=3'b111 load -> same.
- Drop rst_n during BEAT1 of a split store -> all outputs 0 and req_ready=1 immediately. Release and issue LW @0x000 -> normal completion at T+2.
